uart_tx_fsm_core: RTL and testbench

//   UART transmitter, the transmit-side counterpart of the UART receive path.

---
 rtl/uart_tx_fsm_core.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fsm_core.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fsm_core.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB-first, optional parity, one stop bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_fsm_core #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic [5:0]            prescale,
`ifdef UART_TX_PARITY_EN
    input  logic                  par_en,
    input  logic                  par_typ,
`endif
    output logic                  tx_out,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3
    } state_t;
`endif

    state_t                state;
    logic [5:0]            edge_cnt;
    logic [5:0]            pres_m1;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  bit_end;
`ifdef UART_TX_PARITY_EN
    logic                  par_en_q;
    logic                  par_bit_q;
`endif

    // pres_m1 holds the latched prescale minus one, so a prescale of 0 behaves as 1.
    assign bit_end = (edge_cnt == pres_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx_out    <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            pres_m1   <= '0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                edge_cnt <= bit_end ? '0 : edge_cnt + 6'd1;
            end

            case (state)
                IDLE: begin
                    tx_out <= 1'b1;
                    if (data_valid) begin
                        shift_q   <= p_data;
                        pres_m1   <= (prescale == 6'd0) ? 6'd0 : prescale - 6'd1;
`ifdef UART_TX_PARITY_EN
                        par_en_q  <= par_en;
                        par_bit_q <= (^p_data) ^ par_typ;
`endif
                        edge_cnt  <= '0;
                        bit_cnt   <= '0;
                        state     <= START;
                        tx_out    <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        tx_out  <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            if (par_en_q) begin
                                state  <= PARITY;
                                tx_out <= par_bit_q;
                            end else begin
                                state  <= STOP;
                                tx_out <= 1'b1;
                            end
`else
                            state  <= STOP;
                            tx_out <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            tx_out  <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state  <= STOP;
                        tx_out <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (bit_end) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tx_done <= 1'b1;
                        tx_out  <= 1'b1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    tx_out <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm_core.sv
// Testbench for uart_tx_fsm_core: directed and random frames checked against a per-clock frame model.
// Parity scenarios are exercised when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fsm_core;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic [5:0]    prescale;
`ifdef UART_TX_PARITY_EN
    logic          par_en;
    logic          par_typ;
`endif
    logic          tx_out;
    logic          busy;
    logic          tx_done;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_tx_fsm_core #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .prescale   (prescale),
`ifdef UART_TX_PARITY_EN
        .par_en     (par_en),
        .par_typ    (par_typ),
`endif
        .tx_out     (tx_out),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level for bit slot idx of a frame: start, data LSB-first, optional parity, stop.
    function automatic logic frame_bit(input logic [DW-1:0] d, input bit pe, input bit pt, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return d[idx-1];
        if (pe && idx == DW + 1) return (^d) ^ pt;
        return 1'b1;
    endfunction

    task automatic set_req(input logic [DW-1:0] d, input int pres, input bit pe, input bit pt);
        p_data     = d;
        prescale   = 6'(pres);
`ifdef UART_TX_PARITY_EN
        par_en     = pe;
        par_typ    = pt;
`endif
        data_valid = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_tx", tx_out, 1);
            chk("idle_busy", busy, 0);
            chk("idle_done", tx_done, 0);
        end
    endtask

    // Request must already be presented; checks every clock from the accept edge to the done pulse.
    task automatic check_frame(input logic [DW-1:0] d, input int pres_in, input bit pe, input bit pt,
                               input bit hold, input bit junk, input int abort_at);
        int p;
        int total;
        p     = (pres_in == 0) ? 1 : pres_in;
        total = (2 + DW + (pe ? 1 : 0)) * p;
        for (int j = 0; j <= total; j++) begin
            @(posedge clk); #1;
            if (j < total) begin
                chk("tx_bit", tx_out, frame_bit(d, pe, pt, j / p));
                chk("busy_hi", busy, 1);
                chk("done_lo", tx_done, 0);
            end else begin
                chk("tx_end", tx_out, 1);
                chk("busy_end", busy, 0);
                chk("done_pulse", tx_done, 1);
            end
            if (j == abort_at) begin
                rst = 1'b1;
                return;
            end
            if (j < total) begin
                if (junk) begin
                    data_valid = 1'($urandom_range(0, 1));
                    p_data     = DW'($urandom);
                    prescale   = 6'($urandom_range(0, 3));
`ifdef UART_TX_PARITY_EN
                    par_en     = 1'($urandom_range(0, 1));
                    par_typ    = 1'($urandom_range(0, 1));
`endif
                end else if (!hold) begin
                    data_valid = 1'b0;
                end
            end else begin
                data_valid = 1'b0;
            end
        end
    endtask

    initial begin
        logic [DW-1:0] d;
        int            pr;
        bit            pe;
        bit            pt;

        rst        = 1'b1;
        data_valid = 1'b0;
        p_data     = '0;
        prescale   = 6'd16;
`ifdef UART_TX_PARITY_EN
        par_en     = 1'b0;
        par_typ    = 1'b0;
`endif
        @(posedge clk); #1;
        chk("rst_tx", tx_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        rst = 1'b0;
        idle(3);

        // 0x55, no parity, 16 clocks per bit
        set_req(8'h55, 16, 1'b0, 1'b0);
        check_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(3);

        if (HAS_PAR) begin
            set_req(8'hA5, 4, 1'b1, 1'b0);
            check_frame(8'hA5, 4, 1'b1, 1'b0, 1'b0, 1'b0, -1);
            idle(2);
            set_req(8'hFF, 2, 1'b1, 1'b1);
            check_frame(8'hFF, 2, 1'b1, 1'b1, 1'b0, 1'b0, -1);
            idle(1);
            set_req(8'hFF, 2, 1'b1, 1'b0);
            check_frame(8'hFF, 2, 1'b1, 1'b0, 1'b0, 1'b0, -1);
            idle(1);
        end

        // Requests and config changes during a frame must not disturb it or queue a second one
        set_req(8'h3C, 8, 1'b0, 1'b0);
        check_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1);
        idle(4);

        // Reset in the 5th data bit abandons the frame
        d = DW'($urandom);
        set_req(d, 4, 1'b0, 1'b0);
        check_frame(d, 4, 1'b0, 1'b0, 1'b0, 1'b0, 5 * 4 + 1);
        @(posedge clk); #1;
        chk("midrst_tx", tx_out, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", tx_done, 0);
        rst        = 1'b0;
        data_valid = 1'b0;
        idle(2);
        set_req(8'hC3, 3, 1'b0, 1'b0);
        check_frame(8'hC3, 3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(1);

        // Valid held high, prescale 1: two back-to-back frames
        set_req(8'h0F, 1, 1'b0, 1'b0);
        check_frame(8'h0F, 1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        set_req(8'hF0, 1, 1'b0, 1'b0);
        check_frame(8'hF0, 1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(2);

        for (int k = 0; k < 24; k++) begin
            d  = DW'($urandom);
            pr = $urandom_range(0, 7);
            pe = HAS_PAR ? 1'($urandom_range(0, 1)) : 1'b0;
            pt = 1'($urandom_range(0, 1));
            set_req(d, pr, pe, pt);
            check_frame(d, pr, pe, pt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
            idle($urandom_range(0, 2));
        end
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
